// File: rtl/gbe_mdio_pkg.sv
// Shared types and MDIO Clause-22 constants for the PHY speed poller.
package gbe_mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_BMSR,
    ST_RD_SPD,
    ST_UPDATE
  } state_t;

  localparam int unsigned PREAMBLE_LEN  = 32;
  localparam logic [1:0]  MDIO_ST       = 2'b01;
  localparam logic [1:0]  MDIO_OP_RD    = 2'b10;
  localparam logic [4:0]  BMSR_ADDR     = 5'h01;
  localparam int unsigned BMSR_LINK_BIT = 2;

  // Driven portion of a read frame: preamble, ST, OP, PHYAD, REGAD.
  localparam int unsigned HDR_BITS   = PREAMBLE_LEN + 14;
  localparam int unsigned FRAME_BITS = 64;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  function automatic logic [HDR_BITS-1:0] rd_header(input logic [4:0] phyad,
                                                    input logic [4:0] regad);
    return {{PREAMBLE_LEN{1'b1}}, MDIO_ST, MDIO_OP_RD, phyad, regad};
  endfunction

endpackage

// File: rtl/gbe_phy_speed_ctrl_if.sv
// MDIO pad bundle between the management master and the PHY.
interface gbe_phy_speed_ctrl_if;
  logic mdc_o;
  logic mdio_o;
  logic mdio_oe_o;
  logic mdio_i;

  modport master (output mdc_o, output mdio_o, output mdio_oe_o, input mdio_i);
  modport slave  (input mdc_o, input mdio_o, input mdio_oe_o, output mdio_i);
endinterface

// File: rtl/gbe_mdio_rd_frame.sv
// One Clause-22 read frame: MDC divider, header shifter and data capture.
module gbe_mdio_rd_frame
  import gbe_mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 20,
  parameter logic [4:0]  PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  regad,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        done,
  output logic        ta_err,
  output logic [15:0] rdata
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0] BIT_HDR  = 7'(HDR_BITS);
  localparam logic [6:0] BIT_TA2  = 7'(HDR_BITS + 1);
  localparam logic [6:0] BIT_DATA = 7'(HDR_BITS + 2);
  localparam logic [6:0] BIT_END  = 7'(FRAME_BITS);
  localparam logic [5:0] HDR_TOP  = 6'(HDR_BITS - 1);

  logic                active;
  logic                fall_d;
  logic                ta_bad;
  logic [DIV_W-1:0]    div_cnt;
  logic [6:0]          bit_cnt;
  logic [HDR_BITS-1:0] hdr_r;
  logic [15:0]         rx_sr;

  // MDC generation, MDIO drive one clk after MDC falls, sampling on MDC rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      fall_d   <= 1'b0;
      ta_bad   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      hdr_r    <= '0;
      rx_sr    <= '0;
      mdc      <= 1'b0;
      mdio_out <= 1'b1;
      mdio_oe  <= 1'b0;
      done     <= 1'b0;
      ta_err   <= 1'b0;
      rdata    <= '0;
    end else begin
      done   <= 1'b0;
      ta_err <= 1'b0;
      fall_d <= 1'b0;
      if (start && !active) begin
        active   <= 1'b1;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        mdc      <= 1'b0;
        hdr_r    <= rd_header(PHY_ADDR, regad);
        mdio_out <= 1'b1;  // first preamble bit
        mdio_oe  <= 1'b1;
        ta_bad   <= 1'b1;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          mdc     <= ~mdc;
          if (!mdc) begin
            if (bit_cnt == BIT_TA2) ta_bad <= mdio_in;
            if (bit_cnt >= BIT_DATA) rx_sr <= {rx_sr[14:0], mdio_in};
          end else begin
            bit_cnt <= bit_cnt + 7'd1;
            fall_d  <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (fall_d) begin
          if (bit_cnt == BIT_END) begin
            active   <= 1'b0;
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b1;
            done     <= 1'b1;
            ta_err   <= ta_bad;
            rdata    <= rx_sr;
          end else if (bit_cnt < BIT_HDR) begin
            mdio_out <= hdr_r[HDR_TOP - bit_cnt[5:0]];
          end else begin
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/gbe_phy_speed_ctrl.sv
// Polls the PHY over MDIO for link and resolved speed; drives speed select.
module gbe_phy_speed_ctrl
  import gbe_mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 20,
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [4:0]  SPEED_REG   = 5'h11,
  parameter int unsigned SPEED_LSB   = 14,
  parameter int unsigned POLL_PERIOD = 1000000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  gbe_phy_speed_ctrl_if.master        mdio,
  output logic                        link_o,
  output logic [1:0]                  speed_o,
  output logic                        sel_1000m_o,
  output logic                        status_valid_o,
  output logic                        speed_change_o,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam int unsigned TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);

  state_t      state, next_state;
  logic [TMR_W-1:0] timer;
  logic        frm_start, frm_done, frm_ta_err;
  logic [4:0]  frm_regad;
  logic [15:0] frm_rdata;
  logic [1:0]  spd_code;
  logic        spd_known;
  logic        poll_go, err_set;
  logic        pend_link, pend_link_d;
  logic [1:0]  pend_speed, pend_speed_d;
  logic        unused_rdata;

  assign spd_code     = frm_rdata[SPEED_LSB +: 2];
  assign spd_known    = (spd_code == SPD_10) || (spd_code == SPD_100) || (spd_code == SPD_1000);
  assign busy_o       = (state != ST_IDLE);
  assign unused_rdata = ^frm_rdata;

  gbe_mdio_rd_frame #(
    .CLK_DIV  (CLK_DIV),
    .PHY_ADDR (PHY_ADDR)
  ) u_frame (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (frm_start),
    .regad    (frm_regad),
    .mdio_in  (mdio.mdio_i),
    .mdc      (mdio.mdc_o),
    .mdio_out (mdio.mdio_o),
    .mdio_oe  (mdio.mdio_oe_o),
    .done     (frm_done),
    .ta_err   (frm_ta_err),
    .rdata    (frm_rdata)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Poll sequencing: BMSR read, then speed read only while link is up.
  always_comb begin
    next_state   = state;
    frm_start    = 1'b0;
    frm_regad    = BMSR_ADDR;
    poll_go      = 1'b0;
    err_set      = 1'b0;
    pend_link_d  = pend_link;
    pend_speed_d = pend_speed;
    case (state)
      ST_IDLE: begin
        if (en_i && timer == '0) begin
          next_state = ST_RD_BMSR;
          frm_start  = 1'b1;
          poll_go    = 1'b1;
        end
      end
      ST_RD_BMSR: begin
        frm_regad = SPEED_REG;
        if (frm_done) begin
          if (frm_ta_err) begin
            err_set    = 1'b1;
            next_state = ST_IDLE;
          end else if (!frm_rdata[BMSR_LINK_BIT]) begin
            pend_link_d  = 1'b0;
            pend_speed_d = speed_o;
            next_state   = ST_UPDATE;
          end else begin
            frm_start  = 1'b1;
            next_state = ST_RD_SPD;
          end
        end
      end
      ST_RD_SPD: begin
        if (frm_done) begin
          if (frm_ta_err) begin
            err_set    = 1'b1;
            next_state = ST_IDLE;
          end else begin
            pend_link_d  = 1'b1;
            pend_speed_d = spd_known ? spd_code : speed_o;
            next_state   = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Poll timer: reload on poll start, count down to zero and hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              timer <= '0;
    else if (poll_go)       timer <= TMR_RELOAD;
    else if (timer != '0)   timer <= timer - TMR_W'(1);
  end

  // Result of the current poll, held until UPDATE commits it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_link  <= 1'b0;
      pend_speed <= SPD_1000;
    end else begin
      pend_link  <= pend_link_d;
      pend_speed <= pend_speed_d;
    end
  end

  // Status outputs and single-cycle change/error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      link_o         <= 1'b0;
      speed_o        <= SPD_1000;
      sel_1000m_o    <= 1'b1;
      status_valid_o <= 1'b0;
      speed_change_o <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      err_o          <= err_set;
      speed_change_o <= 1'b0;
      if (state == ST_UPDATE) begin
        link_o         <= pend_link;
        speed_o        <= pend_speed;
        sel_1000m_o    <= (pend_speed == SPD_1000);
        status_valid_o <= 1'b1;
        speed_change_o <= (pend_link != link_o) || (pend_speed != speed_o);
      end
    end
  end

endmodule

// File: tb/tb_gbe_phy_speed_ctrl.sv
// Bench: behavioural MDIO PHY, protocol monitor and poll-level reference model.
module tb_gbe_phy_speed_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned POLL    = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic link, sel, valid, chg, err, busy;
  logic [1:0] speed;

  gbe_phy_speed_ctrl_if mif ();

  gbe_phy_speed_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .PHY_ADDR    (5'd0),
    .SPEED_REG   (5'h11),
    .SPEED_LSB   (14),
    .POLL_PERIOD (POLL)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .mdio           (mif),
    .link_o         (link),
    .speed_o        (speed),
    .sel_1000m_o    (sel),
    .status_valid_o (valid),
    .speed_change_o (chg),
    .err_o          (err),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PHY register contents and presence
  logic        phy_present = 1'b1;
  logic [15:0] bmsr = 16'h796D;
  logic [15:0] spd  = 16'h8000;
  logic        phy_drive = 1'b1;
  assign mif.mdio_i = phy_drive;

  // Frame monitor state
  int unsigned bitn = 64;
  logic [45:0] hdr;
  logic [40:0] hdr_exp = {32'hFFFFFFFF, 2'b01, 2'b10, 5'd0};
  logic        oe_bad;
  logic [4:0]  regq[$];
  int unsigned mdc_rises = 0;

  function automatic logic phy_bit(input int unsigned b);
    logic [15:0] d;
    if (!phy_present || hdr[9:5] != 5'd0) return 1'b1;
    d = (hdr[4:0] == 5'h01) ? bmsr : (hdr[4:0] == 5'h11) ? spd : 16'h0000;
    if (b == 47) return 1'b0;
    if (b >= 48 && b <= 63) return d[63 - b];
    return 1'b1;
  endfunction

  // New frame begins when the master starts driving the bus.
  always @(posedge mif.mdio_oe_o) begin
    bitn = 0;
    oe_bad = 1'b0;
    phy_drive = 1'b1;
  end

  // Capture header bits and check drive enable on every MDC rise.
  always @(posedge mif.mdc_o) begin
    mdc_rises++;
    if (bitn < 46) begin
      hdr = {hdr[44:0], mif.mdio_o};
      if (!mif.mdio_oe_o) oe_bad = 1'b1;
    end else if (mif.mdio_oe_o) oe_bad = 1'b1;
    bitn++;
    if (bitn == 46) begin
      check("hdr", hdr[45:5], hdr_exp);
      regq.push_back(hdr[4:0]);
    end
    if (bitn == 64) check("oe_pattern", oe_bad, 1'b0);
  end

  // PHY presents the next bit after each MDC fall.
  always @(negedge mif.mdc_o) phy_drive = phy_bit(bitn);

  // Cycle counter, pulse counters and MDIO-change timing monitor.
  int unsigned cyc = 0, chg_cnt = 0, err_cnt = 0, busy_rises = 0, viol = 0;
  logic mdc_h1 = 1'b0, mdc_h2 = 1'b0, o_h1 = 1'b1, rst_h1 = 1'b1, busy_h = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (chg) chg_cnt++;
    if (err) err_cnt++;
    if (busy && !busy_h) busy_rises++;
    if (!rst && !rst_h1 && mif.mdio_o !== o_h1 && !(mdc_h2 && !mdc_h1)) viol++;
    mdc_h2 = mdc_h1;
    mdc_h1 = mif.mdc_o;
    o_h1   = mif.mdio_o;
    rst_h1 = rst;
    busy_h = busy;
  end

  // Reference model: poll-level status seen by the MAC
  logic       m_link = 1'b0, m_valid = 1'b0;
  logic [1:0] m_speed = 2'b10;
  int unsigned last_start = 0;

  task automatic model_reset();
    m_link = 1'b0; m_speed = 2'b10; m_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mdc"},   mif.mdc_o, 1'b0);
    check({tag, "_mdio"},  mif.mdio_o, 1'b1);
    check({tag, "_oe"},    mif.mdio_oe_o, 1'b0);
    check({tag, "_link"},  link, 1'b0);
    check({tag, "_speed"}, speed, 2'b10);
    check({tag, "_sel"},   sel, 1'b1);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_chg"},   chg, 1'b0);
    check({tag, "_err"},   err, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
  endtask

  task automatic do_poll(input string tag, input bit chain, input bit drop_en);
    int unsigned frames, c0, e0, r0;
    logic exp_link, upd, exp_chg;
    logic [1:0] exp_spd, code;
    upd = 1'b1; exp_link = m_link; exp_spd = m_speed; frames = 1;
    if (!phy_present) upd = 1'b0;
    else if (bmsr[2]) begin
      frames = 2; exp_link = 1'b1; code = spd[15:14];
      if (code != 2'b11) exp_spd = code;
    end else exp_link = 1'b0;
    exp_chg = upd && (exp_link != m_link || exp_spd != m_speed);
    c0 = chg_cnt; e0 = err_cnt; r0 = mdc_rises;
    regq.delete();
    for (int i = 0; i < 2 * POLL && !busy; i++) @(negedge clk);
    check({tag, "_start"}, busy, 1'b1);
    if (chain) check({tag, "_period"}, cyc - last_start, POLL);
    last_start = cyc;
    if (drop_en) begin
      for (int i = 0; i < 400 && bitn < 20; i++) @(negedge clk);
      en = 1'b0;
    end
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check({tag, "_done"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    check({tag, "_link"},  link, exp_link);
    check({tag, "_speed"}, speed, exp_spd);
    check({tag, "_sel"},   sel, exp_spd == 2'b10);
    check({tag, "_valid"}, valid, m_valid | upd);
    check({tag, "_chg_n"}, chg_cnt - c0, exp_chg);
    check({tag, "_err_n"}, err_cnt - e0, !upd);
    check({tag, "_mdc_n"}, mdc_rises - r0, 64 * frames);
    check({tag, "_frames"}, regq.size(), frames);
    for (int i = 0; i < regq.size(); i++)
      check({tag, "_regad"}, regq[i], (i == 0) ? 5'h01 : 5'h11);
    if (upd) begin m_link = exp_link; m_speed = exp_spd; m_valid = 1'b1; end
  endtask

  initial begin
    int unsigned b0, r0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    en = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("first_poll", busy, 1'b1);

    do_poll("p1000", 1'b0, 1'b0);
    spd = 16'h4000;  do_poll("p100", 1'b1, 1'b0);
    do_poll("psame", 1'b1, 1'b0);
    bmsr = 16'h7969; do_poll("plinkdn", 1'b1, 1'b0);
    bmsr = 16'h796D; spd = 16'hC000; do_poll("prsvd", 1'b1, 1'b0);

    // PHY absent from reset
    @(negedge clk) rst = 1'b1;
    phy_present = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_poll("absent1", 1'b0, 1'b0);
    do_poll("absent2", 1'b1, 1'b0);

    // randomized PHY contents
    for (int k = 0; k < 12; k++) begin
      phy_present = ($urandom_range(0, 7) != 0);
      bmsr = 16'($urandom);
      spd  = 16'($urandom);
      do_poll("rand", 1'b1, 1'b0);
    end

    // reset during data phase
    phy_present = 1'b1; bmsr = 16'h796D; spd = 16'h4000;
    for (int i = 0; i < 2 * POLL && !busy; i++) @(negedge clk);
    for (int i = 0; i < 2000 && !(busy && bitn >= 52 && bitn < 64); i++) @(negedge clk);
    check("midrst_reached", bitn >= 52 && bitn < 64, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    model_reset();
    repeat (3) @(negedge clk);
    spd = 16'h0000;
    rst = 1'b0;

    // en dropped mid-frame: poll completes, then bus stays quiet
    do_poll("dropen", 1'b0, 1'b1);
    b0 = busy_rises; r0 = mdc_rises;
    repeat (3 * POLL) @(negedge clk);
    check("idle_busy", busy_rises - b0, 0);
    check("idle_mdc", mdc_rises - r0, 0);
    check("mdio_timing", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
